nv_nvdla_sdp_wdma_reqgen: RTL

NV_NVDLA_SDP_WDMA_REQGEN -- requirements
Module: nv_nvdla_sdp_wdma_reqgen

---
 rtl/nv_nvdla_sdp_wdma_reqgen.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/nv_nvdla_sdp_wdma_reqgen.sv
// SDP write-DMA request generator: splits a layer of lines into bursts of
// command + data requests and tracks outstanding completions.
module nv_nvdla_sdp_wdma_reqgen #(
  parameter int DW        = 64,
  parameter int MAX_BURST = 4,
  parameter int MAX_OUTS  = 8,
  localparam int PD_W     = ((DW > 78) ? DW : 78) + 1
) (
  input  logic            nvdla_core_clk,
  input  logic            nvdla_core_rstn,
  input  logic            op_load,
  input  logic [63:0]     reg2dp_dst_base_addr,
  input  logic [31:0]     reg2dp_dst_line_stride,
  input  logic [12:0]     reg2dp_width,
  input  logic [12:0]     reg2dp_height,
  input  logic            reg2dp_interrupt_ptr,
  input  logic            reg2dp_perf_dma_en,
  input  logic            dat_valid,
  output logic            dat_ready,
  input  logic [DW-1:0]   dat_pd,
  output logic            dma_wr_req_vld,
  input  logic            dma_wr_req_rdy,
  output logic [PD_W-1:0] dma_wr_req_pd,
  input  logic            dma_wr_rsp_complete,
  output logic            dp2reg_done,
  output logic            intr_req_pvld,
  output logic            intr_req_ptr,
  output logic [31:0]     dp2reg_wdma_stall,
  output logic            busy
);

  localparam int BYTES = DW / 8;
  localparam int BSH   = $clog2(BYTES);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCmd     = 2'd1;
  localparam logic [1:0] StData    = 2'd2;
  localparam logic [1:0] StWaitCpl = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] addr_q, addr_d, line_base_q, line_base_d;
  logic [31:0] stride_q, stride_d, stall_q, stall_d;
  logic [12:0] width_q, width_d, height_q, height_d;
  logic [12:0] line_q, line_d, beat_q, beat_d;
  logic [4:0]  len_q, len_d, cnt_q, cnt_d;
  logic [7:0]  outs_q, outs_d;
  logic        ptr_q, ptr_d, perf_en_q, perf_en_d;

  logic [13:0] remain, beat_end;
  logic [4:0]  len_c;
  logic        last_cmd, line_done, cmd_hs, dat_hs, cpl_dec;
  logic [63:0] base_masked;

  assign remain      = {1'b0, width_q} + 14'd1 - {1'b0, beat_q};
  assign len_c       = (remain > 14'(MAX_BURST)) ? 5'(MAX_BURST) : remain[4:0];
  assign last_cmd    = (line_q == height_q) && (remain <= 14'(MAX_BURST));
  assign beat_end    = {1'b0, beat_q} + {9'd0, len_q};
  assign line_done   = beat_end > {1'b0, width_q};
  assign base_masked = reg2dp_dst_base_addr & ~((64'd1 << BSH) - 64'd1);

  assign cmd_hs  = (state_q == StCmd) && dma_wr_req_vld && dma_wr_req_rdy;
  assign dat_hs  = (state_q == StData) && dat_valid && dma_wr_req_rdy;
  assign cpl_dec = dma_wr_rsp_complete && (outs_q != 8'd0);

  assign busy              = (state_q != StIdle);
  assign dp2reg_done       = (state_q == StWaitCpl) && (outs_q == 8'd0);
  assign intr_req_pvld     = dp2reg_done;
  assign intr_req_ptr      = dp2reg_done & ptr_q;
  assign dp2reg_wdma_stall = stall_q;

  // Payload is built purely from registers in CMD, so it holds while stalled.
  always_comb begin
    dma_wr_req_vld = 1'b0;
    dat_ready      = 1'b0;
    dma_wr_req_pd  = '0;
    case (state_q)
      StCmd: begin
        dma_wr_req_vld         = (outs_q < 8'(MAX_OUTS));
        dma_wr_req_pd[PD_W-1]  = 1'b1;
        dma_wr_req_pd[63:0]    = addr_q;
        dma_wr_req_pd[76:64]   = 13'(len_c - 5'd1);
        dma_wr_req_pd[77]      = last_cmd;
      end
      StData: begin
        dma_wr_req_vld         = dat_valid;
        dat_ready              = dma_wr_req_rdy;
        dma_wr_req_pd[DW-1:0]  = dat_pd;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    line_base_d = line_base_q;
    stride_d    = stride_q;
    width_d     = width_q;
    height_d    = height_q;
    line_d      = line_q;
    beat_d      = beat_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    perf_en_d   = perf_en_q;
    case (state_q)
      StIdle: begin
        if (op_load) begin
          addr_d      = base_masked;
          line_base_d = base_masked;
          stride_d    = reg2dp_dst_line_stride;
          width_d     = reg2dp_width;
          height_d    = reg2dp_height;
          ptr_d       = reg2dp_interrupt_ptr;
          perf_en_d   = reg2dp_perf_dma_en;
          line_d      = '0;
          beat_d      = '0;
          cnt_d       = '0;
          state_d     = StCmd;
        end
      end
      StCmd: begin
        if (cmd_hs) begin
          len_d   = len_c;
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (dat_hs) begin
          if (cnt_q == len_q - 5'd1) begin
            cnt_d = '0;
            if (!line_done) begin
              addr_d  = addr_q + (64'(len_q) << BSH);
              beat_d  = beat_end[12:0];
              state_d = StCmd;
            end else if (line_q < height_q) begin
              line_base_d = line_base_q + {32'd0, stride_q};
              addr_d      = line_base_q + {32'd0, stride_q};
              beat_d      = '0;
              line_d      = line_q + 13'd1;
              state_d     = StCmd;
            end else begin
              state_d = StWaitCpl;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        if (dp2reg_done) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    outs_d = outs_q;
    if (cmd_hs && !cpl_dec) outs_d = outs_q + 8'd1;
    else if (!cmd_hs && cpl_dec) outs_d = outs_q - 8'd1;
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StIdle) && op_load) begin
      stall_d = '0;
    end else if (busy && perf_en_q && dma_wr_req_vld && !dma_wr_req_rdy &&
                 (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      line_base_q <= '0;
      stride_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      outs_q      <= '0;
      ptr_q       <= 1'b0;
      perf_en_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      line_base_q <= line_base_d;
      stride_q    <= stride_d;
      width_q     <= width_d;
      height_q    <= height_d;
      line_q      <= line_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      outs_q      <= outs_d;
      ptr_q       <= ptr_d;
      perf_en_q   <= perf_en_d;
      stall_q     <= stall_d;
    end
  end

endmodule
